// File: rtl/register_file.sv
// 32-entry MIPS register file: two combinational read ports with optional
// same-cycle write bypass, one synchronous write port and a stored-only debug port.
module register_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter bit                    BYPASS     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [4:0]            write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [4:0]            read_reg1,
    input  logic [4:0]            read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic [4:0]            debug_reg,
    output logic [DATA_WIDTH-1:0] debug_data
);

    localparam logic [4:0] SP_INDEX = 5'd29;

    logic [DATA_WIDTH-1:0] regs [0:31];
    logic                  write_active;
    logic                  bypass_hit1;
    logic                  bypass_hit2;

    // Entry 0 is cleared on reset and never written; reads also force it to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (5'(i) == SP_INDEX) ? SP_INIT : '0;
            end
        end else if (write_active) begin
            regs[write_reg] <= write_data;
        end
    end

    assign write_active = reg_write && (write_reg != 5'd0);

    // Bypass is gated by reset so a write launched during reset never leaks out.
    assign bypass_hit1 = BYPASS && !reset && write_active && (write_reg == read_reg1);
    assign bypass_hit2 = BYPASS && !reset && write_active && (write_reg == read_reg2);

    always_comb begin
        read_data1 = '0;
        if (read_reg1 != 5'd0) begin
            read_data1 = bypass_hit1 ? write_data : regs[read_reg1];
        end
    end

    always_comb begin
        read_data2 = '0;
        if (read_reg2 != 5'd0) begin
            read_data2 = bypass_hit2 ? write_data : regs[read_reg2];
        end
    end

    always_comb begin
        debug_data = '0;
        if (debug_reg != 5'd0) begin
            debug_data = regs[debug_reg];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: runs a bypassing and a non-bypassing instance
// side by side on shared stimulus and compares against hand-computed vectors.
module tb_register_file;

    localparam logic [31:0] SP_VAL = 32'h0000_3FFC;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  debug_reg;
    logic [31:0] byp_rd1, byp_rd2, byp_dbg;
    logic [31:0] nb_rd1, nb_rd2, nb_dbg;

    int num_compared;
    int num_mismatched;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  dbg;
        logic [31:0] exp_byp1;
        logic [31:0] exp_byp2;
        logic [31:0] exp_nb1;
        logic [31:0] exp_nb2;
        logic [31:0] exp_dbg;
    } vec_t;

    localparam int NUM_VECS = 12;
    vec_t vecs [NUM_VECS];

    register_file #(.DATA_WIDTH(32), .BYPASS(1'b1), .SP_INIT(SP_VAL)) dut_byp (
        .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(byp_rd1), .read_data2(byp_rd2),
        .debug_reg(debug_reg), .debug_data(byp_dbg)
    );

    register_file #(.DATA_WIDTH(32), .BYPASS(1'b0), .SP_INIT(SP_VAL)) dut_nb (
        .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(nb_rd1), .read_data2(nb_rd2),
        .debug_reg(debug_reg), .debug_data(nb_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                  input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [4:0] dbg);
        reg_write  = we;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        debug_reg  = dbg;
    endtask

    // Global time limit so a broken clock or stuck run still ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        num_compared   = 0;
        num_mismatched = 0;
        reset = 1'b0;
        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Expected values assume reset contents: 29 = SP_VAL, everything else 0.
        vecs[0]  = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd9,  5'd8,
                     32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 5'd9,  32'h00000005, 5'd8,  5'd9,  5'd8,
                     32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 5'd9,  32'h0, 5'd8,  5'd9,  5'd8,
                     32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h5, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0, 5'd0,  5'd8,  5'd0,
                     32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        vecs[5]  = '{1'b1, 5'd10, 32'h11111111, 5'd10, 5'd29, 5'd10,
                     32'h11111111, SP_VAL, 32'h0, SP_VAL, 32'h0};
        vecs[6]  = '{1'b1, 5'd10, 32'h22222222, 5'd10, 5'd10, 5'd10,
                     32'h22222222, 32'h22222222, 32'h11111111, 32'h11111111, 32'h11111111};
        vecs[7]  = '{1'b0, 5'd10, 32'h0, 5'd10, 5'd10, 5'd10,
                     32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222};
        vecs[8]  = '{1'b1, 5'd29, 32'h00001000, 5'd29, 5'd31, 5'd29,
                     32'h00001000, 32'h0, SP_VAL, 32'h0, SP_VAL};
        vecs[9]  = '{1'b0, 5'd29, 32'h0, 5'd29, 5'd8,  5'd29,
                     32'h00001000, 32'hDEADBEEF, 32'h00001000, 32'hDEADBEEF, 32'h00001000};
        vecs[10] = '{1'b1, 5'd31, 32'h80000000, 5'd30, 5'd31, 5'd31,
                     32'h0, 32'h80000000, 32'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 5'd31, 32'h0, 5'd31, 5'd30, 5'd31,
                     32'h80000000, 32'h0, 32'h80000000, 32'h0, 32'h80000000};

        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            debug_reg = 5'(i);
            #1;
            check_output($sformatf("reset rd1[%0d]", i), byp_rd1, (i == 29) ? SP_VAL : 32'h0);
            check_output($sformatf("reset dbg[%0d]", i), nb_dbg, (i == 29) ? SP_VAL : 32'h0);
        end

        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd29, 5'd5, 5'd29);
        repeat (3) @(posedge clk);
        #1;
        check_output("idle rd1[29]", byp_rd1, SP_VAL);
        check_output("idle rd2[5]", nb_rd2, 32'h0);
        check_output("idle dbg[29]", byp_dbg, SP_VAL);

        for (int i = 0; i < NUM_VECS; i++) begin
            @(posedge clk);
            #1;
            apply_stimulus(vecs[i].we, vecs[i].wr, vecs[i].wd,
                           vecs[i].r1, vecs[i].r2, vecs[i].dbg);
            #3;
            check_output($sformatf("vec%0d byp rd1", i), byp_rd1, vecs[i].exp_byp1);
            check_output($sformatf("vec%0d byp rd2", i), byp_rd2, vecs[i].exp_byp2);
            check_output($sformatf("vec%0d byp dbg", i), byp_dbg, vecs[i].exp_dbg);
            check_output($sformatf("vec%0d nb rd1", i),  nb_rd1,  vecs[i].exp_nb1);
            check_output($sformatf("vec%0d nb rd2", i),  nb_rd2,  vecs[i].exp_nb2);
            check_output($sformatf("vec%0d nb dbg", i),  nb_dbg,  vecs[i].exp_dbg);
        end

        // Reset raised together with a write to $sp: the write must never surface.
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply_stimulus(1'b1, 5'd29, 32'hABCD0000, 5'd29, 5'd29, 5'd29);
        #1;
        check_output("rstwr byp rd1 pre", byp_rd1, SP_VAL);
        check_output("rstwr byp rd2 pre", byp_rd2, SP_VAL);
        check_output("rstwr nb rd1 pre", nb_rd1, SP_VAL);
        check_output("rstwr dbg pre", byp_dbg, SP_VAL);
        @(posedge clk);
        #1;
        check_output("rstwr byp rd1 post", byp_rd1, SP_VAL);
        check_output("rstwr dbg post", byp_dbg, SP_VAL);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 32'h0, 5'd29, 5'd8, 5'd10);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_output("after rst rd1[29]", byp_rd1, SP_VAL);
        check_output("after rst rd2[8]", byp_rd2, 32'h0);
        check_output("after rst dbg[10]", nb_dbg, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
